maxpool_stream_2d: RTL and testbench

- Streaming 2D pooling engine for the CNN feature-map path. It is the parametrised successor of the fixed 64-bit, fixed-window max-pooling block.
- Accepts raster-order pixels packed LANES per beat and performs non-overlapping POOLxPOOL max or min pooling over an IMG_W x IMG_H frame.
- Emits pooled pixels packed LANES/POOL per beat, with valid/ready backpressure on both sides.
- Sits between the conv output buffer and the next layer's input FIFO.

---
 rtl/maxpool_stream_2d.sv | 185 ++++++++++++++++++
 tb/tb_maxpool_stream_2d.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_2d.sv
// Streaming non-overlapping POOLxPOOL max/min pooling over a raster-order frame.
// Input beats carry LANES pixels; each output beat carries LANES/POOL pooled pixels.
module maxpool_stream_2d #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int POOL   = 2,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int SIGNED = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_mode,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [DATA_W*LANES-1:0]          i_data,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [DATA_W*(LANES/POOL)-1:0]   o_data,
  output logic                             o_last,
  output logic                             o_busy
);

  localparam int OUT_L = LANES / POOL;
  localparam int BEATS = IMG_W / LANES;
  localparam int DEPTH = IMG_W / POOL;
  localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WIN_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);

  // True when the later value should replace the earlier one; ties keep the earlier.
  function automatic logic take_new(input logic [DATA_W-1:0] old_v,
                                    input logic [DATA_W-1:0] new_v,
                                    input logic              min_m);
    logic gt_s;
    logic lt_s;
    if (SIGNED != 0) begin
      gt_s = $signed(new_v) > $signed(old_v);
      lt_s = $signed(new_v) < $signed(old_v);
    end else begin
      gt_s = new_v > old_v;
      lt_s = new_v < old_v;
    end
    return min_m ? lt_s : gt_s;
  endfunction

  function automatic logic [DATA_W-1:0] reduce2(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic              min_m);
    return take_new(old_v, new_v, min_m) ? new_v : old_v;
  endfunction

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              o_valid_q, o_valid_d;
  logic              o_last_q, o_last_d;
  logic [DATA_W*OUT_L-1:0] o_data_q, o_data_d;
  logic [DATA_W-1:0] rowbuf_q [DEPTH];
  logic [DATA_W-1:0] rowbuf_d [DEPTH];

  logic              i_ready_s;
  logic              accept_s;
  logic              mode_s;
  logic [DATA_W-1:0] part_s [OUT_L];
  logic [DATA_W-1:0] cur_s  [OUT_L];
  logic [DATA_W-1:0] comb_s [OUT_L];

  assign i_ready_s = !o_valid_q || o_ready;
  assign accept_s  = i_valid && i_ready_s;
  // Mode is taken from the port only on the first beat of a frame.
  assign mode_s    = ((col_q == '0) && (row_q == '0)) ? i_mode : mode_q;

  // Horizontal reduce of the beat and vertical reduce against the row buffer.
  always_comb begin
    for (int j = 0; j < OUT_L; j++) begin
      part_s[j] = i_data[(j*POOL)*DATA_W +: DATA_W];
      for (int k = 1; k < POOL; k++) begin
        part_s[j] = reduce2(part_s[j], i_data[(j*POOL+k)*DATA_W +: DATA_W], mode_s);
      end
      cur_s[j] = '0;
      for (int c = 0; c < BEATS; c++) begin
        cur_s[j] = cur_s[j] | ((COL_W'(c) == col_q) ? rowbuf_q[c*OUT_L+j] : {DATA_W{1'b0}});
      end
      comb_s[j] = reduce2(cur_s[j], part_s[j], mode_s);
    end
  end

  // Row buffer update: first window row overwrites, later rows accumulate.
  always_comb begin
    for (int c = 0; c < BEATS; c++) begin
      for (int j = 0; j < OUT_L; j++) begin
        rowbuf_d[c*OUT_L+j] = (accept_s && (COL_W'(c) == col_q))
                              ? ((win_q == '0) ? part_s[j] : comb_s[j])
                              : rowbuf_q[c*OUT_L+j];
      end
    end
  end

  // Frame position counters and latched mode.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    mode_d = mode_q;
    if (accept_s) begin
      mode_d = mode_s;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          win_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
          win_d = (win_q == WIN_LAST) ? WIN_W'(0) : (win_q + WIN_W'(1));
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Output register; a reload in the same cycle as a drain replaces the old beat.
  always_comb begin
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_data_d  = o_data_q;
    if (accept_s && (win_q == WIN_LAST)) begin
      o_valid_d = 1'b1;
      o_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
      for (int j = 0; j < OUT_L; j++) begin
        o_data_d[j*DATA_W +: DATA_W] = comb_s[j];
      end
    end else if (o_ready) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // Busy while the frame is partially consumed or its last beat is still pending.
  assign busy_d = !((col_d == '0) && (row_d == '0)) || (o_valid_d && o_last_d);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        rowbuf_q[e] <= '0;
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_data_q  <= o_data_d;
      rowbuf_q  <= rowbuf_d;
    end
  end

  assign i_ready = i_ready_s;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_maxpool_stream_2d.sv
// Randomized bench for maxpool_stream_2d: 8x4 frames, 2x2 pooling, unsigned and
// signed instances in lockstep, checked against a window-level reference model.
module tb_maxpool_stream_2d;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mode;
  logic        i_valid;
  logic [63:0] i_data;
  logic        o_ready;
  logic        i_ready_u, o_valid_u, o_last_u, o_busy_u;
  logic        i_ready_s, o_valid_s, o_last_s, o_busy_s;
  logic [31:0] o_data_u, o_data_s;

  always #5 clk = ~clk;

  maxpool_stream_2d #(.DATA_W(16), .LANES(4), .POOL(2), .IMG_W(W), .IMG_H(H), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .i_ready(i_ready_u),
    .i_data(i_data), .o_valid(o_valid_u), .o_ready(o_ready), .o_data(o_data_u),
    .o_last(o_last_u), .o_busy(o_busy_u));

  maxpool_stream_2d #(.DATA_W(16), .LANES(4), .POOL(2), .IMG_W(W), .IMG_H(H), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .i_ready(i_ready_s),
    .i_data(i_data), .o_valid(o_valid_s), .o_ready(o_ready), .o_data(o_data_s),
    .o_last(o_last_s), .o_busy(o_busy_s));

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic [15:0] fr [H][W];
  exp_t        eq_u [$];
  exp_t        eq_s [$];
  exp_t        mon_u, mon_s;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          n_out0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pv(input logic [15:0] p, input int sg);
    return (sg != 0) ? int'($signed(p)) : int'({16'd0, p});
  endfunction

  // Reference: each 2x2 window reduced directly from the frame array.
  task automatic push_exp(input logic md);
    exp_t        e;
    logic [15:0] best, v;
    int          wc;
    for (int sg = 0; sg < 2; sg++)
      for (int wr = 0; wr < H/2; wr++)
        for (int k = 0; k < W/4; k++) begin
          e.d = '0;
          for (int o = 0; o < 2; o++) begin
            wc = k*2 + o;
            best = fr[2*wr][2*wc];
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                v = fr[2*wr+dr][2*wc+dc];
                if (md ? (pv(v, sg) < pv(best, sg)) : (pv(v, sg) > pv(best, sg))) best = v;
              end
            e.d[o*16 +: 16] = best;
          end
          e.l = (((wr*2+1)*(W/4)) + k) == (H*W/4 - 1);
          if (sg == 0) eq_u.push_back(e);
          else eq_s.push_back(e);
        end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = 16'(r*W + c);
  endtask

  task automatic fill_rand(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = (kind == 0) ? (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0001)
                               : 16'($urandom);
  endtask

  // Drives nb beats of fr; optional mode toggle, idle gaps, random o_ready, latency check.
  task automatic send(input int nb, input logic md, input bit tog, input bit gaps,
                      input bit rnd_rdy, input bit lat);
    int r, c;
    bit acc;
    for (int b = 0; b < nb; b++) begin
      r = b / (W/4);
      c = b % (W/4);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        i_valid = 1'b0;
        if (rnd_rdy) o_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      i_valid = 1'b1;
      i_mode  = (tog && b > 0) ? ~md : md;
      for (int l = 0; l < 4; l++) i_data[l*16 +: 16] = fr[r][c*4+l];
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        if (rnd_rdy) o_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = i_ready_u;
        @(posedge clk); #1;
      end
      if (!acc) begin
        chk("accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
        return;
      end
      if (lat) chk("lat_valid", 64'(o_valid_u), 64'(r % 2));
    end
    i_valid = 1'b0;
    if (rnd_rdy) o_ready = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (eq_u.size() > 0 || eq_s.size() > 0); t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_u", 64'(eq_u.size()), 64'd0);
    chk("drain_s", 64'(eq_s.size()), 64'd0);
    chk("idle_busy", 64'(o_busy_u), 64'd0);
  endtask

  // Output monitor: every transfer is matched against the head of its queue.
  always @(negedge clk) begin
    if (!rst && o_valid_u && o_ready) begin
      n_out++;
      if (eq_u.size() == 0) chk("extra_out_u", 64'd1, 64'd0);
      else begin
        mon_u = eq_u.pop_front();
        chk("data_u", 64'(o_data_u), 64'(mon_u.d));
        chk("last_u", 64'(o_last_u), 64'(mon_u.l));
      end
    end
    if (!rst && o_valid_s && o_ready) begin
      if (eq_s.size() == 0) chk("extra_out_s", 64'd1, 64'd0);
      else begin
        mon_s = eq_s.pop_front();
        chk("data_s", 64'(o_data_s), 64'(mon_s.d));
        chk("last_s", 64'(o_last_s), 64'(mon_s.l));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_mode = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 64'(o_valid_u), 64'd0);
    chk("rst_o_data", 64'(o_data_u), 64'd0);
    chk("rst_o_last", 64'(o_last_u), 64'd0);
    chk("rst_o_busy", 64'(o_busy_u), 64'd0);
    chk("rst_i_ready", 64'(i_ready_u), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Max ramp with per-beat latency check.
    fill_ramp();
    push_exp(1'b0);
    send(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("busy_last_pending", 64'(o_busy_u), 64'd1);
    drain();

    // Min ramp, then min ramp with i_mode toggled after the first beat.
    push_exp(1'b1);
    send(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    push_exp(1'b1);
    send(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    push_exp(1'b0);
    send(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // 0xFFFF / 0x0001 mixtures, compared signed and unsigned at once.
    for (int f = 0; f < 3; f++) begin
      fill_rand(0);
      fr[0][0] = 16'hFFFF; fr[0][1] = 16'h0001; fr[1][0] = 16'hFFFF; fr[1][1] = 16'hFFFF;
      push_exp(1'b0);
      send(8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drain();
    end

    // Backpressure held at the first output.
    fill_ramp();
    push_exp(1'b0);
    o_ready = 1'b0;
    fork
      send(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        for (int t = 0; t < 50 && !o_valid_u; t++) @(posedge clk);
        #1;
        chk("bp_valid", 64'(o_valid_u), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_data", 64'(o_data_u), 64'({16'd11, 16'd9}));
          chk("bp_i_ready", 64'(i_ready_u), 64'd0);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-frame with an output still pending.
    o_ready = 1'b0;
    send(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(o_valid_u), 64'd1);
    chk("pre_rst_busy", 64'(o_busy_u), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", 64'(o_valid_u), 64'd0);
    chk("post_rst_busy", 64'(o_busy_u), 64'd0);
    rst = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0);
    send(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Two random frames back to back with gaps and random downstream stalls.
    for (int rep = 0; rep < 3; rep++) begin
      n_out0 = n_out;
      for (int f = 0; f < 2; f++) begin
        logic md;
        md = 1'($urandom_range(0, 1));
        fill_rand(1);
        push_exp(md);
        send(8, md, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      drain();
      chk("b2b_count", 64'(n_out - n_out0), 64'd8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
